keyb_scan_ctrl: RTL and testbench
=================================

KEYB_SCAN_CTRL -- requirements
Module: keyb_scan_ctrl

Interface
REQ-001 Parameter: SCAN_DIV, default 1000, clk cycles each column is driven during scan (minimum 4).
REQ-002 Parameter: DEBOUNCE_CYCLES, default 50000, consecutive stable cycles for press and release qualification (minimum 2).
REQ-003 Port: clk  in  1  system clock, all logic on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low; reset==0 forces the reset state immediately, independent of clk.
REQ-005 Port: row_in  in  4  keypad rows, active-low, asynchronous to clk.
REQ-006 Port: col_out  out  4  keypad column drive, active-low one-hot.
REQ-007 Port: key_code  out  4  qualified key index = row*4 + col.
REQ-008 Port: key_valid  out  1  key_code holds a qualified, unconsumed key.
REQ-009 Port: key_ready  in  1  consumer accepts key_code when high with key_valid.
REQ-010 Port: busy  out  1  high in every state except SCAN.

Function
REQ-011 row_in SHALL pass through a 2-flop synchronizer; every reference to "rows" below means the synchronized value.
REQ-012 The FSM SHALL have exactly four states: SCAN, DEBOUNCE, VALID, RELEASE.
REQ-013 SCAN: a dwell counter SHALL count 0..SCAN_DIV-1 per column; col_out SHALL advance 0->1->2->3->0 when the counter wraps.
REQ-014 SCAN: rows SHALL be sampled only on the cycle the dwell counter equals SCAN_DIV-1; if any row is low, the lowest-index low row and the current column SHALL be latched, and the FSM SHALL enter DEBOUNCE with col_out frozen.
REQ-015 DEBOUNCE: a 32-bit counter SHALL increment each cycle the latched row stays low; it SHALL reach DEBOUNCE_CYCLES-1 before the transition to VALID.
REQ-016 DEBOUNCE: if the latched row goes high on any cycle, the FSM SHALL return to SCAN with the next column and the dwell counter at 0; key_valid SHALL not assert.
REQ-017 On the DEBOUNCE->VALID transition, key_code SHALL load row*4+col, and key_valid SHALL go high on the same registered edge.
REQ-018 VALID: key_valid and key_code SHALL hold stable until a cycle with key_valid==1 and key_ready==1; key_valid SHALL drop on the next edge and the FSM SHALL enter RELEASE.
REQ-019 key_ready SHALL be ignored outside VALID, and key_ready high on the first VALID cycle SHALL complete the handshake in one cycle.
REQ-020 VALID: key release before the handshake SHALL NOT withdraw key_valid; the key stays pending.
REQ-021 RELEASE: col_out SHALL stay frozen, and the counter SHALL clear whenever any row is low; the FSM SHALL return to SCAN (next column, dwell 0) after DEBOUNCE_CYCLES consecutive all-rows-high cycles.
REQ-022 key_code SHALL retain the last accepted value outside VALID.
REQ-023 Exactly one key_valid assertion SHALL occur per physical press, regardless of hold time.
REQ-024 Press-to-valid latency SHALL be 2 (sync) + at most SCAN_DIV (dwell) + DEBOUNCE_CYCLES cycles.

Reset
REQ-025 While reset==0: state SCAN, col_out=4'b1110, key_code=4'h0, key_valid=0, busy=0, counters=0, synchronizer flops=4'b1111.
REQ-026 Reset assertion SHALL abort any state mid-operation, including VALID with a pending key, and the key SHALL be lost.
REQ-027 Reset deassertion SHALL be synchronized internally so the first active edge is glitch-free; scanning SHALL begin at column 0.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-028 Idle, all rows high for 64 cycles -> col_out cycles 1110,1101,1011,0111 every 4 clks; key_valid=0; busy=0.
REQ-029 Hold row 2 low while col_out=1011 (col 2) for 40 cycles, key_ready=1 -> exactly one key_valid pulse with key_code=4'hA; busy=1 until 8 all-high cycles after release.
REQ-030 Bounce: row 0 low for 3 cycles then high during col 1 -> no key_valid; FSM back in SCAN; col_out=1011 next.
REQ-031 Hold row 3 col 3 with key_ready=0 for 30 cycles, then release, then key_ready=1 -> key_valid stays high with key_code=4'hF until key_ready, then drops on the next edge.
REQ-032 Rows 1 and 3 both low on col 0 -> key_code=4'h4 (lowest row wins).
REQ-033 Assert reset asynchronously mid-VALID -> key_valid=0 and col_out=1110 without a clock edge; after release, scanning restarts at column 0.

Source files
------------

// File: rtl/keyb_scan_ctrl.sv
// 4x4 keypad scanner: walks an active-low column strobe, debounces the first key seen,
// hands its index over a valid/ready handshake and waits for a clean release before rescanning.
module keyb_scan_ctrl #(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       busy
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        VALID,
        RELEASE
    } state_t;

    // Assert asynchronously, release on a clock edge so no flop sees a runt reset removal.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic [3:0] row_meta_q;
    logic [3:0] row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= '1;
            row_q      <= '1;
        end else begin
            row_meta_q <= row_in;
            row_q      <= row_meta_q;
        end
    end

    state_t        state_q;
    logic [DW-1:0] dwell_q;
    logic [31:0]   cnt_q;
    logic [1:0]    col_q;
    logic [1:0]    row_sel_q;
    logic [3:0]    col_out_q;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          busy_q;

    logic       any_low;
    logic [1:0] low_row;
    logic       sel_high;
    logic       dwell_end;
    logic       cnt_end;

    always_comb begin
        any_low = (row_q != 4'hF);
        low_row = 2'd0;
        // Scan from the top so the lowest-index low row is the final assignment.
        for (int unsigned i = 0; i < 4; i++) begin
            if (!row_q[3 - i]) begin
                low_row = 2'(3 - i);
            end
        end
        sel_high  = row_q[row_sel_q];
        dwell_end = (dwell_q == DW'(SCAN_DIV - 1));
        cnt_end   = (cnt_q == 32'(DEBOUNCE_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            dwell_q     <= '0;
            cnt_q       <= '0;
            col_q       <= '0;
            row_sel_q   <= '0;
            col_out_q   <= 4'b1110;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                SCAN: begin
                    if (dwell_end) begin
                        dwell_q <= '0;
                        if (any_low) begin
                            row_sel_q <= low_row;
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= DEBOUNCE;
                        end else begin
                            col_q     <= col_q + 2'd1;
                            col_out_q <= {col_out_q[2:0], col_out_q[3]};
                        end
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end

                DEBOUNCE: begin
                    if (sel_high) begin
                        col_q     <= col_q + 2'd1;
                        col_out_q <= {col_out_q[2:0], col_out_q[3]};
                        dwell_q   <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= SCAN;
                    end else if (cnt_end) begin
                        key_code_q  <= {row_sel_q, col_q};
                        key_valid_q <= 1'b1;
                        state_q     <= VALID;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end

                VALID: begin
                    // Rows are ignored here: a key released early stays pending.
                    if (key_ready) begin
                        key_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= RELEASE;
                    end
                end

                RELEASE: begin
                    if (any_low) begin
                        cnt_q <= '0;
                    end else if (cnt_end) begin
                        col_q     <= col_q + 2'd1;
                        col_out_q <= {col_out_q[2:0], col_out_q[3]};
                        dwell_q   <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= SCAN;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end

                default: begin
                    state_q <= SCAN;
                end
            endcase
        end
    end

    assign col_out   = col_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_keyb_scan_ctrl.sv
// Bench for keyb_scan_ctrl: a keypad matrix model driven by random presses, with every output
// checked each cycle against event times derived from the scan/debounce/handshake rules.
module tb_keyb_scan_ctrl;

    localparam int SD  = 4;
    localparam int DEB = 8;
    localparam int BIG = 1 << 30;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic        busy;
    logic [15:0] pressed   = '0;

    int         n      = 0;
    int         errs   = 0;
    int         checks = 0;
    int         scan_s = BIG;
    int         scan_k = 0;
    logic [3:0] code_cur = '0;

    keyb_scan_ctrl #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its row low while its column is driven low.
    always_comb begin
        row_in = '1;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[r * 4 + c] && (col_out[c] == 1'b0)) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, n, act, exp);
        end
    endtask

    function automatic int col_at(input int s, input int k, input int t);
        return (t < s) ? k : (k + (t - s) / SD) % 4;
    endfunction

    task automatic check_cycle(input int col, input bit bsy, input bit vld, input logic [3:0] code);
        logic [3:0] oh;
        oh = 4'b0001 << col;
        oh = ~oh;
        check("col_out", 32'(col_out), 32'(oh));
        check("busy", 32'(busy), 32'(bsy));
        check("key_valid", 32'(key_valid), 32'(vld));
        check("key_code", 32'(key_code), 32'(code));
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            n++;
            check_cycle(col_at(scan_s, scan_k, n), 1'b0, 1'b0, code_cur);
        end
    endtask

    // Hold reset low for some cycles, then release; scanning starts two edges later at column 0.
    task automatic hold_reset(input int cycles);
        idle(cycles);
        reset  = 1'b1;
        scan_s = n + 2;
        scan_k = 0;
    endtask

    // One press of key (r,c), optionally with a second row xr in the same column, held for
    // `hold` cycles starting `dly` cycles from now; key_ready rises rdy_off cycles after the press.
    task automatic run_key(input int r, input int c, input int xr, input int hold, input int dly,
                           input int rdy_off, input bit align, input bit rst_mid);
        int         tp, tr, rf, e, v, h, fin, last, j, lo, ecol;
        bit         seen, qual, ebusy, p;
        logic [3:0] newcode;
        tp = n + dly;
        j  = (tp + 3 - scan_s + SD - 1) / SD;
        if (j < 1) j = 1;
        while ((scan_k + j - 1) % 4 != c) j++;
        e = scan_s + j * SD;
        if (align) tp = e - 3;
        tr   = tp + hold;
        rf   = tp + rdy_off;
        seen = (e - 3 < tr);
        qual = seen && (tr >= e + DEB - 2);
        v    = e + DEB;
        h    = ((rf > v) ? rf : v) + 1;
        if (!seen)      fin = tr;
        else if (!qual) fin = tr + 3;
        else            fin = (h > tr + 2) ? h + DEB : tr + 2 + DEB;
        lo      = (xr >= 0 && xr < r) ? xr : r;
        newcode = 4'(lo * 4 + c);
        last    = fin + int'($urandom_range(1, 6));
        while (n < last) begin
            @(negedge clk);
            n++;
            ebusy = seen && (n >= e) && (n < fin);
            if (ebusy)                  ecol = c;
            else if (seen && n >= fin)  ecol = col_at(fin, (c + 1) % 4, n);
            else                        ecol = col_at(scan_s, scan_k, n);
            check_cycle(ecol, ebusy, qual && (n >= v) && (n < h),
                        (qual && n >= v) ? newcode : code_cur);
            p = (n >= tp) && (n < tr);
            pressed[r * 4 + c] = p;
            if (xr >= 0) pressed[xr * 4 + c] = p;
            key_ready = qual ? ((n >= rf) && (n < h)) : (n >= rf);
            if (rst_mid && qual && n == v + 2) begin
                reset     = 1'b0;
                pressed   = '0;
                key_ready = 1'b0;
                #1;
                check("async_col_out", 32'(col_out), 32'hE);
                check("async_key_valid", 32'(key_valid), 32'h0);
                check("async_busy", 32'(busy), 32'h0);
                check("async_key_code", 32'(key_code), 32'h0);
                code_cur = '0;
                scan_s   = BIG;
                scan_k   = 0;
                return;
            end
        end
        key_ready = 1'b0;
        if (seen) begin
            scan_s = fin;
            scan_k = (c + 1) % 4;
        end
        if (qual) code_cur = newcode;
    endtask

    task automatic run_random();
        int r, c, xr, hold;
        bit al;
        r  = int'($urandom_range(0, 3));
        c  = int'($urandom_range(0, 3));
        xr = -1;
        if ($urandom_range(0, 4) == 0) begin
            xr = int'($urandom_range(0, 3));
            if (xr == r) xr = -1;
        end
        hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : int'($urandom_range(10, 45));
        al   = ($urandom_range(0, 3) == 0);
        run_key(r, c, xr, hold, int'($urandom_range(1, 16)), int'($urandom_range(0, 40)), al, 1'b0);
    endtask

    initial begin
        #1 reset = 1'b0;
        hold_reset(3);
        idle(64);
        run_key(2, 2, -1, 40, 3, 0, 1'b0, 1'b0);
        run_key(0, 1, -1, 3, 1, 40, 1'b1, 1'b0);
        run_key(3, 3, -1, 30, 2, 45, 1'b0, 1'b0);
        run_key(1, 0, 3, 40, 1, 0, 1'b0, 1'b0);
        repeat (40) run_random();
        run_key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, 60, 2, 1000, 1'b1, 1'b1);
        hold_reset(2);
        idle(24);
        repeat (8) run_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
